// File: rtl/dct_block_arbiter_if.sv
// ----------------------------------------------------------------------------
// dct_block_arbiter_if
//   Bundles every handshake/bus signal around dct_block_arbiter: the two
//   row-stream requesters, the row interface into the forward DCT, the DCT
//   output monitor taps, and the tag/status outputs.
//
//   slave  : the arbiter side (accepts requester rows, drives the DCT input)
//   master : the environment side (requesters, DCT model, tag consumer)
//
//   Signals
//     s{0,1}_valid/_data/_sob/_eob/_sof : requester row + framing (to arbiter)
//     s{0,1}_ready                      : row accepted when valid&ready
//     dct_in_valid/_data/_sob/_eob/_sof : registered row into the DCT
//     dct_out_valid/_eob                : DCT output row monitor (pops tags)
//     tag_valid/tag_src                 : oldest block in flight and its source
//     err_proto                         : one-cycle protocol-violation pulse
//     busy                              : block in progress or tags pending
// ----------------------------------------------------------------------------
interface dct_block_arbiter_if #(
    parameter int W_I = 8
);
    localparam int ROW_W = 8 * W_I;

    logic             s0_valid;
    logic             s0_ready;
    logic [ROW_W-1:0] s0_data;
    logic             s0_sob;
    logic             s0_eob;
    logic             s0_sof;

    logic             s1_valid;
    logic             s1_ready;
    logic [ROW_W-1:0] s1_data;
    logic             s1_sob;
    logic             s1_eob;
    logic             s1_sof;

    logic             dct_in_valid;
    logic [ROW_W-1:0] dct_in_data;
    logic             dct_in_sob;
    logic             dct_in_eob;
    logic             dct_in_sof;

    logic             dct_out_valid;
    logic             dct_out_eob;

    logic             tag_valid;
    logic             tag_src;
    logic             err_proto;
    logic             busy;

    modport slave (
        input  s0_valid, s0_data, s0_sob, s0_eob, s0_sof,
        output s0_ready,
        input  s1_valid, s1_data, s1_sob, s1_eob, s1_sof,
        output s1_ready,
        output dct_in_valid, dct_in_data, dct_in_sob, dct_in_eob, dct_in_sof,
        input  dct_out_valid, dct_out_eob,
        output tag_valid, tag_src, err_proto, busy
    );

    modport master (
        output s0_valid, s0_data, s0_sob, s0_eob, s0_sof,
        input  s0_ready,
        output s1_valid, s1_data, s1_sob, s1_eob, s1_sof,
        input  s1_ready,
        input  dct_in_valid, dct_in_data, dct_in_sob, dct_in_eob, dct_in_sof,
        output dct_out_valid, dct_out_eob,
        input  tag_valid, tag_src, err_proto, busy
    );
endinterface

// File: rtl/dct_block_arbiter.sv
// ----------------------------------------------------------------------------
// dct_block_arbiter
//   Shares one forward-DCT pipeline between two row-stream requesters.
//   Arbitration happens once per 8x8 block (round robin); the granted
//   requester then streams its 8 rows, each registered into the DCT input one
//   cycle after acceptance. The source of every granted block is pushed into
//   an in-order tag FIFO and popped when the DCT emits the block's last row,
//   so downstream logic can demultiplex DCT output blocks.
//
//   Ports
//     clk : clock
//     rst : synchronous active-high reset
//     bus : dct_block_arbiter_if.slave (requesters, DCT in/out, tags, status)
//
//   err_proto is registered: it pulses the cycle after the offending event
//   (dropped row, wrong sob/eob inside a block, tag pop while empty).
// ----------------------------------------------------------------------------
module dct_block_arbiter #(
    parameter int W_I       = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dct_block_arbiter_if.slave   bus
);
    localparam int ROW_W = 8 * W_I;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d, cur_state;
    logic               sel_q, sel_d;
    logic               last_grant_q, last_grant_d;
    logic [2:0]         row_cnt_q, row_cnt_d;
    logic               vld_q, vld_d;
    logic [ROW_W-1:0]   data_q, data_d;
    logic               sob_q, sob_d;
    logic               eob_q, eob_d;
    logic               sof_q, sof_d;
    logic               err_q, err_d;

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tag_mem_q [TAG_DEPTH];

    logic               cand0, cand1, grant, grant_src;
    logic               fifo_empty, fifo_full, pop_req, pop;
    logic               row_valid, row_sob, row_eob, row_sof;
    logic [ROW_W-1:0]   row_data;
    logic               first_row, last_row;

    // While reset is held the handshakes behave as in IDLE; the block in
    // progress is abandoned at the reset edge anyway.
    assign cur_state = rst ? IDLE : state_q;

    assign cand0      = bus.s0_valid && bus.s0_sob;
    assign cand1      = bus.s1_valid && bus.s1_sob;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign pop_req    = bus.dct_out_valid && bus.dct_out_eob;
    assign pop        = pop_req && !fifo_empty;

    // Row fields of the requester currently owning the DCT.
    assign row_valid  = sel_q ? bus.s1_valid : bus.s0_valid;
    assign row_data   = sel_q ? bus.s1_data  : bus.s0_data;
    assign row_sob    = sel_q ? bus.s1_sob   : bus.s0_sob;
    assign row_eob    = sel_q ? bus.s1_eob   : bus.s0_eob;
    assign row_sof    = sel_q ? bus.s1_sof   : bus.s0_sof;
    assign first_row  = (row_cnt_q == 3'd0);
    assign last_row   = (row_cnt_q == 3'd7);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        row_cnt_d    = row_cnt_q;
        vld_d        = 1'b0;
        data_d       = data_q;
        sob_d        = 1'b0;
        eob_d        = 1'b0;
        sof_d        = 1'b0;
        err_d        = pop_req && fifo_empty;
        grant        = 1'b0;
        grant_src    = 1'b0;
        bus.s0_ready = 1'b0;
        bus.s1_ready = 1'b0;

        case (cur_state)
            IDLE: begin
                // A row without sob is swallowed here so the requester can
                // resynchronise on the next block start.
                bus.s0_ready = bus.s0_valid && !bus.s0_sob;
                bus.s1_ready = bus.s1_valid && !bus.s1_sob;
                if ((bus.s0_valid && !bus.s0_sob) || (bus.s1_valid && !bus.s1_sob)) begin
                    err_d = 1'b1;
                end
                // A full FIFO still admits a grant when a pop frees a slot
                // in the same cycle.
                if ((cand0 || cand1) && (!fifo_full || pop)) begin
                    grant        = 1'b1;
                    grant_src    = (cand0 && cand1) ? !last_grant_q : cand1;
                    sel_d        = grant_src;
                    last_grant_d = grant_src;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                bus.s0_ready = !sel_q;
                bus.s1_ready = sel_q;
                if (row_valid) begin
                    // Framing is regenerated from row_cnt; the block is
                    // always exactly 8 rows whatever the requester flagged.
                    vld_d     = 1'b1;
                    data_d    = row_data;
                    sob_d     = first_row;
                    eob_d     = last_row;
                    sof_d     = row_sof && first_row;
                    row_cnt_d = row_cnt_q + 3'd1;
                    if ((row_sob != first_row) || (row_eob != last_row)) begin
                        err_d = 1'b1;
                    end
                    if (last_row) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            row_cnt_q    <= 3'd0;
            vld_q        <= 1'b0;
            data_q       <= '0;
            sob_q        <= 1'b0;
            eob_q        <= 1'b0;
            sof_q        <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            row_cnt_q    <= row_cnt_d;
            vld_q        <= vld_d;
            data_q       <= data_d;
            sob_q        <= sob_d;
            eob_q        <= eob_d;
            sof_q        <= sof_d;
            err_q        <= err_d;
            if (grant) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (grant && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !grant) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // NOTE: tag storage has no reset; validity comes from the reset
    // pointers/count, and tag_src is gated so it reads 0 when empty.
    always_ff @(posedge clk) begin
        if (grant && !rst) begin
            tag_mem_q[wr_ptr_q] <= grant_src;
        end
    end

    assign bus.dct_in_valid = vld_q;
    assign bus.dct_in_data  = data_q;
    assign bus.dct_in_sob   = sob_q;
    assign bus.dct_in_eob   = eob_q;
    assign bus.dct_in_sof   = sof_q;
    assign bus.err_proto    = err_q;
    assign bus.tag_valid    = !fifo_empty;
    assign bus.tag_src      = !fifo_empty && tag_mem_q[rd_ptr_q];
    assign bus.busy         = (state_q == BUSY) || !fifo_empty;
endmodule

// File: tb/tb_dct_block_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dct_block_arbiter
//   Directed bench for dct_block_arbiter. Inputs change on the falling edge,
//   outputs are read on or just after the falling edge. A monitor records
//   every DCT input row with the rising-edge count at which it was
//   registered; drivers record the edge at which each row was accepted.
// ----------------------------------------------------------------------------
module tb_dct_block_arbiter;
    localparam int W_I        = 8;
    localparam int TAG_DEPTH  = 4;
    localparam int ROW_BUDGET = 200;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  flags;   // {sob, eob, sof}
        int          cyc;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   err_cnt = 0;
    row_t mon_q[$];
    int   acc0_q[$];
    int   acc1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct_block_arbiter_if #(.W_I(W_I)) bus ();

    dct_block_arbiter #(
        .W_I       (W_I),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.dct_in_valid) begin
            mon_q.push_back('{data: bus.dct_in_data,
                              flags: {bus.dct_in_sob, bus.dct_in_eob, bus.dct_in_sof},
                              cyc: cyc});
        end
        if (bus.err_proto) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_row(input bit src, input int blk, input int r);
        return {8'(src), 8'(blk), 8'(r), 40'hC0FFEE1234 ^ 40'(blk * 37 + r)};
    endfunction

    task automatic set_src(input bit src, input logic v, input logic [63:0] d,
                           input logic sob, input logic eob, input logic sof);
        if (!src) begin
            bus.s0_valid = v; bus.s0_data = d; bus.s0_sob = sob; bus.s0_eob = eob; bus.s0_sof = sof;
        end else begin
            bus.s1_valid = v; bus.s1_data = d; bus.s1_sob = sob; bus.s1_eob = eob; bus.s1_sof = sof;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_src(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        set_src(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        bus.dct_out_valid = 1'b0;
        bus.dct_out_eob   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        mon_q.delete();
        acc0_q.delete();
        acc1_q.delete();
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Streams nrows rows of one block; gap_max>0 inserts 1..gap_max idle
    // cycles before each row after the first. eob is flagged on eob_row.
    task automatic send_block(input bit src, input int blk, input logic sof,
                              input int eob_row, input int gap_max, input int nrows);
        logic rdy;
        bit   ok;
        for (int r = 0; r < nrows; r++) begin
            if (r > 0 && gap_max > 0) begin
                set_src(src, 1'b0, '0, 1'b0, 1'b0, 1'b0);
                repeat ($urandom_range(gap_max, 1)) @(negedge clk);
            end
            set_src(src, 1'b1, mk_row(src, blk, r), r == 0, r == eob_row, sof);
            ok = 1'b0;
            for (int c = 0; c < ROW_BUDGET && !ok; c++) begin
                #1;
                rdy = src ? bus.s1_ready : bus.s0_ready;
                @(negedge clk);
                if (rdy) begin
                    ok = 1'b1;
                    if (src) acc1_q.push_back(cyc);
                    else     acc0_q.push_back(cyc);
                end
            end
            if (!ok) begin
                check($sformatf("accept_s%0d_b%0d_r%0d", src, blk, r), ok, 1'b1);
                set_src(src, 1'b0, '0, 1'b0, 1'b0, 1'b0);
                return;
            end
        end
        set_src(src, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_tag();
        bus.dct_out_valid = 1'b1;
        bus.dct_out_eob   = 1'b1;
        @(negedge clk);
        bus.dct_out_valid = 1'b0;
        bus.dct_out_eob   = 1'b0;
        #1;
    endtask

    // Checks 8 monitored rows starting at base against the expected block.
    task automatic check_rows(input int base, input bit src, input int blk, input logic sof);
        if (mon_q.size() < base + 8) begin
            check($sformatf("rows_s%0d_b%0d", src, blk), mon_q.size(), base + 8);
            return;
        end
        for (int r = 0; r < 8; r++) begin
            check($sformatf("s%0d_b%0d_r%0d_data", src, blk, r), mon_q[base + r].data, mk_row(src, blk, r));
            check($sformatf("s%0d_b%0d_r%0d_flags", src, blk, r), mon_q[base + r].flags,
                  {r == 0, r == 7, sof && (r == 0)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int rdy_cnt;
        int base;

        // ---- reset state ---------------------------------------------------
        do_reset();
        check("rst_dct_valid", bus.dct_in_valid, 1'b0);
        check("rst_dct_data",  bus.dct_in_data, 64'h0);
        check("rst_tag_valid", bus.tag_valid, 1'b0);
        check("rst_tag_src",   bus.tag_src, 1'b0);
        check("rst_err",       bus.err_proto, 1'b0);
        check("rst_busy",      bus.busy, 1'b0);
        check("rst_ready",     {bus.s0_ready, bus.s1_ready}, 2'b00);

        // ---- single block from s0, back to back -----------------------------
        // valid seen at edge start+1 (grant), row 0 accepted at start+2.
        start = cyc;
        send_block(1'b0, 0, 1'b1, 7, 0, 8);
        settle();
        check("t1_rows", mon_q.size(), 8);
        if (mon_q.size() == 8) begin
            check("t1_first_cyc", mon_q[0].cyc, start + 2);
            check("t1_last_cyc",  mon_q[7].cyc, start + 9);
        end
        check_rows(0, 1'b0, 0, 1'b1);
        check("t1_tag_valid", bus.tag_valid, 1'b1);
        check("t1_tag_src",   bus.tag_src, 1'b0);
        check("t1_busy",      bus.busy, 1'b1);
        pop_tag();
        check("t1_tag_popped", bus.tag_valid, 1'b0);
        check("t1_idle",       bus.busy, 1'b0);

        // ---- both requesters, continuous sob-valid, round robin ------------
        do_reset();
        start = cyc;
        fork
            begin
                send_block(1'b0, 0, 1'b1, 7, 0, 8);
                send_block(1'b0, 1, 1'b0, 7, 0, 8);
            end
            begin
                send_block(1'b1, 0, 1'b0, 7, 0, 8);
                send_block(1'b1, 1, 1'b1, 7, 0, 8);
            end
        join
        settle();
        check("t2_rows", mon_q.size(), 32);
        if (mon_q.size() == 32) begin
            check("t2_first_cyc", mon_q[0].cyc, start + 2);
            check("t2_last_cyc",  mon_q[31].cyc, start + 36);
        end
        check_rows(0,  1'b0, 0, 1'b1);
        check_rows(8,  1'b1, 0, 1'b0);
        check_rows(16, 1'b0, 1, 1'b0);
        check_rows(24, 1'b1, 1, 1'b1);
        check("t2_tag0", bus.tag_src, 1'b0);
        pop_tag();
        check("t2_tag1", bus.tag_src, 1'b1);
        pop_tag();
        check("t2_tag2", bus.tag_src, 1'b0);
        pop_tag();
        check("t2_tag3", bus.tag_src, 1'b1);
        pop_tag();
        check("t2_tags_empty", bus.tag_valid, 1'b0);

        // ---- tag FIFO full: 4 blocks max, one pop releases one grant --------
        do_reset();
        for (int b = 0; b < 4; b++) send_block(1'b0, b, b == 0, 7, 0, 8);
        set_src(1'b0, 1'b1, mk_row(1'b0, 4, 0), 1'b1, 1'b0, 1'b0);
        rdy_cnt = 0;
        repeat (12) begin
            #1;
            rdy_cnt += int'(bus.s0_ready);
            @(negedge clk);
        end
        #1;
        check("t3_full_ready", rdy_cnt, 0);
        check("t3_full_rows",  mon_q.size(), 32);
        check("t3_full_busy",  bus.busy, 1'b1);
        check("t3_full_tag",   bus.tag_valid, 1'b1);
        pop_tag();
        check("t3_pop_grant", bus.s0_ready, 1'b1);
        send_block(1'b0, 4, 1'b0, 7, 0, 8);
        set_src(1'b0, 1'b1, mk_row(1'b0, 5, 0), 1'b1, 1'b0, 1'b0);
        rdy_cnt = 0;
        repeat (12) begin
            #1;
            rdy_cnt += int'(bus.s0_ready);
            @(negedge clk);
        end
        #1;
        check("t3_refull_ready", rdy_cnt, 0);
        check("t3_refull_rows",  mon_q.size(), 40);
        check_rows(32, 1'b0, 4, 1'b0);

        // ---- s1 with gaps, s0 starves for the whole block -------------------
        do_reset();
        fork
            send_block(1'b1, 0, 1'b1, 7, 5, 8);
            begin
                repeat (2) @(negedge clk);
                send_block(1'b0, 0, 1'b0, 7, 0, 8);
            end
        join
        settle();
        check("t4_rows", mon_q.size(), 16);
        check_rows(0, 1'b1, 0, 1'b1);
        check_rows(8, 1'b0, 0, 1'b0);
        if (mon_q.size() >= 8 && acc1_q.size() == 8) begin
            for (int r = 0; r < 8; r++) begin
                check($sformatf("t4_row%0d_cyc", r), mon_q[r].cyc, acc1_q[r]);
            end
        end
        if (acc0_q.size() > 0 && acc1_q.size() == 8) begin
            check("t4_s0_after_s1", acc0_q[0], acc1_q[7] + 2);
        end

        // ---- protocol errors ------------------------------------------------
        do_reset();
        set_src(1'b0, 1'b1, mk_row(1'b0, 7, 3), 1'b0, 1'b0, 1'b0);
        #1;
        check("t5_drop_ready", bus.s0_ready, 1'b1);
        @(negedge clk);
        set_src(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t5_drop_err", bus.err_proto, 1'b1);
        @(negedge clk);
        #1;
        check("t5_drop_err_off", bus.err_proto, 1'b0);
        check("t5_drop_no_grant", bus.busy, 1'b0);
        check("t5_drop_no_row", mon_q.size(), 0);

        base = err_cnt;
        send_block(1'b0, 2, 1'b0, 5, 0, 8);
        settle();
        check("t5_eob_err_cnt", err_cnt - base, 2);
        check("t5_eob_rows", mon_q.size(), 8);
        check_rows(0, 1'b0, 2, 1'b0);

        pop_tag();
        check("t5_pop_ok", bus.tag_valid, 1'b0);
        base = err_cnt;
        pop_tag();
        settle();
        check("t5_pop_empty_err", err_cnt - base, 1);
        check("t5_pop_empty_busy", bus.busy, 1'b0);

        // ---- reset mid-block with 2 tags queued -----------------------------
        do_reset();
        send_block(1'b0, 0, 1'b1, 7, 0, 8);
        send_block(1'b0, 1, 1'b0, 7, 0, 4);
        set_src(1'b0, 1'b1, mk_row(1'b0, 1, 4), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t6_dct_valid", bus.dct_in_valid, 1'b0);
        check("t6_tag_valid", bus.tag_valid, 1'b0);
        check("t6_busy",      bus.busy, 1'b0);
        rst = 1'b0;
        set_src(1'b0, 1'b1, mk_row(1'b0, 9, 0), 1'b1, 1'b0, 1'b0);
        set_src(1'b1, 1'b1, mk_row(1'b1, 9, 0), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("t6_first_grant", {bus.s0_ready, bus.s1_ready}, 2'b10);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
